mux_scan_n: RTL
===============

MUX_SCAN_N -- requirements
Module: mux_scan_n

Interface
REQ-001 Parameter WIDTH, default 1, bit width of each channel.
REQ-002 Parameter CHANNELS, default 16, number of input channels, legal range 2..256.
REQ-003 Derived localparam SEL_W = clog2(CHANNELS), minimum 1; it is not overridable.
REQ-004 Port clk, input, 1, single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1, reset; synchronous and active-low.
REQ-006 Port data_in, input, CHANNELS*WIDTH, channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 Port mode, input, 1, selects the mode: 0 = manual single-channel, 1 = scan all channels.
REQ-008 Port sel_in, input, SEL_W, channel index used in manual mode.
REQ-009 Port start, input, 1, requests a transaction; sampled in IDLE only.
REQ-010 Port abort, input, 1, terminates the transaction in progress.
REQ-011 Port out_data, output, WIDTH, registered snapshot of the selected channel.
REQ-012 Port out_ch, output, SEL_W, index of the channel held on out_data.
REQ-013 Port out_valid, output, 1, out_data and out_ch are valid.
REQ-014 Port out_ready, input, 1, the consumer accepts the current word.
REQ-015 Port out_last, output, 1, the current word is the final word of the transaction.
REQ-016 Port out_err, output, 1, a manual select was out of range.
REQ-017 Port busy, output, 1, the block is not in IDLE.

Function
REQ-018 The FSM shall have exactly two states, IDLE and HOLD; busy = (state == HOLD).
REQ-019 In IDLE with start=1 and mode=0, the block shall load data_in[sel_in] into out_data, sel_in into out_ch, and assert out_valid=1 and out_last=1 on the next edge; the FSM then enters HOLD.
REQ-020 If sel_in >= CHANNELS in manual mode, the block shall load out_data=0, set out_err=1 and out_last=1, and still present the word with out_valid=1.
REQ-021 In IDLE with start=1 and mode=1, the block shall load the first eligible channel (channel 0 when masking is absent) with out_valid=1; the FSM then enters HOLD.
REQ-022 Start-to-out_valid latency shall be exactly 1 cycle.
REQ-023 A handshake is a cycle in which out_valid=1 and out_ready=1 on the same rising edge.
REQ-024 In HOLD, out_data, out_ch, out_last and out_err shall stay stable until a handshake or an abort occurs.
REQ-025 On a scan handshake with out_last=0, the block shall load the next eligible channel in ascending index order on the same edge, with out_valid remaining 1 (no bubble).
REQ-026 out_last shall be 1 exactly when out_ch is the highest eligible channel.
REQ-027 On a handshake with out_last=1, the FSM shall return to IDLE and clear out_valid, out_last and out_err.
REQ-028 abort=1 in HOLD shall return the FSM to IDLE and clear out_valid on the next edge; abort has priority over a simultaneous handshake.
REQ-029 In IDLE, abort shall be ignored.
REQ-030 start, mode and sel_in shall be ignored while the FSM is in HOLD.
REQ-031 data_in shall be sampled only on load edges; changes on data_in while a word is held shall not alter out_data.
REQ-032 A new start may be accepted in the cycle after the return to IDLE, not in the same cycle.

Reset
REQ-033 When rst_n=0 at a rising edge, the block shall set state=IDLE, out_data=0, out_ch=0, out_valid=0, out_last=0, out_err=0 and busy=0.
REQ-034 Reset shall take priority over start, abort and any handshake, including reset asserted in the middle of a scan.

Configuration
REQ-035 Macro MUX_SCAN_MASK_EN, when defined, shall add input port ch_mask (width CHANNELS, bit k=1 enables channel k), and scan mode shall visit only enabled channels.
REQ-036 With MUX_SCAN_MASK_EN defined and ch_mask all zero, the block shall ignore a scan start and remain in IDLE.
REQ-037 With MUX_SCAN_MASK_EN defined, manual mode shall ignore ch_mask.
REQ-038 ch_mask shall be evaluated on each load edge.
REQ-039 Without MUX_SCAN_MASK_EN, the ch_mask port shall be absent and every channel shall be eligible.

Verification
REQ-040 Manual select, WIDTH=8 CHANNELS=16, data_in channel k = k+0x10, sel_in=5, start pulse -> next cycle out_data=0x15, out_ch=5, out_valid=1, out_last=1; out_ready=1 -> IDLE.
REQ-041 Scan with out_ready held at 1 -> 16 consecutive valid words 0x10..0x1F, no gaps, out_last only on channel 15, busy falls after that word.
REQ-042 Scan with out_ready=0 for 3 cycles on channel 2 while data_in changes -> out_data held at the original value; abort together with out_ready=1 -> IDLE, out_valid=0.
REQ-043 CHANNELS=12 (non-power-of-two), manual sel_in=13 -> out_err=1, out_data=0, out_valid=1; a scan ends with out_last on channel 11.
REQ-044 rst_n=0 during scan at channel 7 -> all outputs 0 next edge; a new start then begins at channel 0.
REQ-045 MUX_SCAN_MASK_EN defined, ch_mask=0x8421 -> scan delivers channels 0, 5, 10, 15 only, out_last on 15; ch_mask=0 with start -> busy stays 0.

Source files
------------

// File: rtl/mux_scan_n.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan_n
// Brief    : Registered channel mux with manual select or ascending scan of all
//            eligible channels over a valid/ready handshake. Optional channel
//            mask enabled by the MUX_SCAN_MASK_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module mux_scan_n #(
    parameter int  WIDTH    = 1,
    parameter int  CHANNELS = 16,
    localparam int SEL_W    = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic                      start,
    input  logic                      abort,
`ifdef MUX_SCAN_MASK_EN
    input  logic [CHANNELS-1:0]       ch_mask,
`endif
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_ch,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic                      out_err,
    output logic                      busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t               state;
    logic [CHANNELS-1:0]  elig;
    logic                 any_elig;
    logic [SEL_W-1:0]     first_idx;
    logic [SEL_W-1:0]     last_idx;
    logic [SEL_W-1:0]     next_idx;
    logic                 next_found;
    logic [31:0]          sel_ext;
    logic                 sel_ok;
    logic                 handshake;

`ifdef MUX_SCAN_MASK_EN
    assign elig = ch_mask;
`else
    assign elig = '1;
`endif

    assign sel_ext   = {{(32-SEL_W){1'b0}}, sel_in};
    assign sel_ok    = (sel_ext < 32'(CHANNELS));
    assign handshake = out_valid && out_ready;
    assign busy      = (state == HOLD);

    function automatic logic [WIDTH-1:0] pick(input logic [CHANNELS*WIDTH-1:0] d,
                                              input logic [SEL_W-1:0]          idx);
        pick = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (idx == SEL_W'(k)) pick = d[k*WIDTH +: WIDTH];
        end
    endfunction

    // Lowest eligible, highest eligible, and lowest eligible above the held channel.
    always_comb begin
        any_elig   = 1'b0;
        first_idx  = '0;
        last_idx   = '0;
        next_idx   = '0;
        next_found = 1'b0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (elig[k]) begin
                first_idx = SEL_W'(k);
                any_elig  = 1'b1;
                if (SEL_W'(k) > out_ch) begin
                    next_idx   = SEL_W'(k);
                    next_found = 1'b1;
                end
            end
        end
        for (int k = 0; k < CHANNELS; k++) begin
            if (elig[k]) last_idx = SEL_W'(k);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_err   <= 1'b0;
        end else if (state == IDLE) begin
            if (start && !mode) begin
                out_data  <= sel_ok ? pick(data_in, sel_in) : '0;
                out_ch    <= sel_in;
                out_err   <= !sel_ok;
                out_last  <= 1'b1;
                out_valid <= 1'b1;
                state     <= HOLD;
            end else if (start && mode && any_elig) begin
                out_data  <= pick(data_in, first_idx);
                out_ch    <= first_idx;
                out_err   <= 1'b0;
                out_last  <= (first_idx == last_idx);
                out_valid <= 1'b1;
                state     <= HOLD;
            end
        end else begin
            if (abort) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                out_err   <= 1'b0;
                state     <= IDLE;
            end else if (handshake) begin
                // A mask change mid-scan can leave nothing above; end the scan then.
                if (out_last || !next_found) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    out_err   <= 1'b0;
                    state     <= IDLE;
                end else begin
                    out_data <= pick(data_in, next_idx);
                    out_ch   <= next_idx;
                    out_last <= (next_idx == last_idx);
                end
            end
        end
    end

endmodule
`default_nettype wire
